pll_lock_reset_ctrl: RTL
========================

PLL_LOCK_RESET_CTRL -- requirements
Module: pll_lock_reset_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on pll_locked; legal range 2 to 4.
REQ-002 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before the hold phase; minimum 1.
REQ-003 Parameter RESET_HOLD_CYCLES, default 16: extra cycles sys_rst stays asserted after lock is qualified; minimum 1.
REQ-004 clk  input  1  system clock, the PLL c0 output; all logic rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 pll_locked  input  1  PLL lock status; asynchronous to clk and may glitch.
REQ-007 clear_count  input  1  synchronous, single-cycle request to zero lock_loss_count.
REQ-008 sys_rst  output  1  active-high reset to the design domain; asserts asynchronously, deasserts synchronously to clk.
REQ-009 rst_done  output  1  high only in RUN.
REQ-010 lock_lost_pulse  output  1  one-cycle pulse on each loss of lock while in RUN.
REQ-011 lock_loss_count  output  8  saturating count of lock losses seen in RUN.
REQ-012 state_o  output  2  current FSM state: 0 WAIT_LOCK, 1 STABLE, 2 HOLD, 3 RUN.

Function
REQ-013 pll_locked SHALL pass through a SYNC_STAGES-deep flop chain; locked_s, the last stage, is the only lock value the FSM uses.
REQ-014 One down-counter or up-counter of width clog2(max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES)+1) SHALL serve both the STABLE and HOLD phases.
REQ-015 WAIT_LOCK: sys_rst=1 and the counter is held at 0; locked_s=1 moves the FSM to STABLE.
REQ-016 STABLE: sys_rst=1 and the counter increments while locked_s=1.
REQ-017 STABLE: locked_s=0 returns the FSM to WAIT_LOCK with the counter cleared; no loss event is raised.
REQ-018 STABLE: once LOCK_STABLE_CYCLES consecutive locked cycles have been counted, the FSM moves to HOLD with the counter cleared.
REQ-019 HOLD: sys_rst=1 and the counter increments.
REQ-020 HOLD: locked_s=0 returns the FSM to WAIT_LOCK; no loss event is raised.
REQ-021 HOLD: after RESET_HOLD_CYCLES cycles the FSM moves to RUN.
REQ-022 RUN: sys_rst=0 and rst_done=1; locked_s=0 moves the FSM to WAIT_LOCK.
REQ-023 On the RUN-exit edge, lock_lost_pulse=1 for exactly one cycle, lock_loss_count increments, and sys_rst and rst_done take their WAIT_LOCK values on that same edge.
REQ-024 Lock latency: with pll_locked held high from the edge first sampling it high (edge 1), sys_rst SHALL fall on edge SYNC_STAGES+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES+1.
REQ-025 Loss latency: sys_rst SHALL rise on edge SYNC_STAGES+1 after the edge first sampling pll_locked low.
REQ-026 Any locked_s low pulse of at least one cycle SHALL restart qualification from WAIT_LOCK; no glitch filtering beyond the synchronizer.
REQ-027 lock_loss_count SHALL saturate at 255; a further loss still pulses lock_lost_pulse but leaves the count unchanged.
REQ-028 clear_count zeroes lock_loss_count on the next edge.
REQ-029 clear_count in the same cycle as a loss event SHALL give lock_loss_count=1: clear applies first, then the increment.
REQ-030 All outputs SHALL be registered; sys_rst, rst_done and lock_lost_pulse SHALL be glitch-free.

Reset
REQ-031 rst=1 SHALL immediately, without a clock, force sys_rst=1, rst_done=0, lock_lost_pulse=0, lock_loss_count=0, state_o=0, counter=0 and all synchronizer stages=0.
REQ-032 rst asserted mid-operation, including in RUN, SHALL NOT count as a lock loss.
REQ-033 After rst falls, qualification SHALL restart from WAIT_LOCK even if pll_locked is already high.

Verification (SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4 unless stated)
REQ-034 Clean lock: pll_locked rises and stays high -> sys_rst falls and rst_done rises on edge 15; state_o steps 0,1,2,3.
REQ-035 Glitch during STABLE: pll_locked low for 1 cycle after 5 locked cycles -> state_o returns to 0, lock_lost_pulse stays 0, count stays 0, and after re-lock sys_rst falls 15 edges later.
REQ-036 Loss in RUN: pll_locked drops -> sys_rst=1 on edge 3, lock_lost_pulse high one cycle, lock_loss_count=1, and re-lock requalifies in 15 edges.
REQ-037 Saturation and clear: 256 loss/re-lock cycles -> count=255; clear_count together with a loss -> count=1; clear_count alone -> count=0.
REQ-038 Async reset in RUN: rst pulsed with no clock edge -> sys_rst=1 and rst_done=0 immediately, count=0, no lock_lost_pulse; with pll_locked high, sys_rst falls 15 edges after rst release.
REQ-039 Defaults: with default parameters, pll_locked high -> sys_rst falls on edge 1043.

Source files
------------

// File: rtl/pll_lock_reset_ctrl.sv
// -----------------------------------------------------------------------------
// pll_lock_reset_ctrl
//
// Generates the design-domain reset from the PLL lock indication. The lock
// signal is synchronized, then qualified: it must stay high for
// LOCK_STABLE_CYCLES consecutive cycles. After that, sys_rst is held for
// another RESET_HOLD_CYCLES before it is released. Any loss of lock sends the
// controller back to WAIT_LOCK. A loss seen while running is also reported
// as a one-cycle pulse and counted in a saturating counter.
//
// Ports
//   clk              system clock (PLL c0 output), rising edge
//   rst              asynchronous active-high reset
//   pll_locked       raw PLL lock status, asynchronous to clk, may glitch
//   clear_count      single-cycle request to zero lock_loss_count
//   sys_rst          active-high design reset: async assert, sync deassert
//   rst_done         high only while the controller is in RUN
//   lock_lost_pulse  one-cycle pulse on each loss of lock while in RUN
//   lock_loss_count  saturating (255) count of lock losses seen in RUN
//   state_o          FSM state: 0 WAIT_LOCK, 1 STABLE, 2 HOLD, 3 RUN
// -----------------------------------------------------------------------------
module pll_lock_reset_ctrl #(
   parameter int SYNC_STAGES        = 2,    // legal range 2..4
   parameter int LOCK_STABLE_CYCLES = 1024, // minimum 1
   parameter int RESET_HOLD_CYCLES  = 16    // minimum 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       clear_count,
   output logic       sys_rst,
   output logic       rst_done,
   output logic       lock_lost_pulse,
   output logic [7:0] lock_loss_count,
   output logic [1:0] state_o
);

   // One counter serves both the STABLE and HOLD phases, so it is sized for
   // the longer of the two.
   localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                               LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t                   state_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [SYNC_STAGES-1:0]   sync_q;
   logic                     locked_s;

   // Synchronizer chain. A new sample enters at bit 0, and the top bit is the
   // only lock value the FSM ever looks at.
   // NOTE: sequential state uses non-blocking assignments only. This way every
   // flop samples the values from before the edge, whatever the statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      end
   end

   assign locked_s = sync_q[SYNC_STAGES-1];

   // Qualification FSM. Every output is a flop, so sys_rst, rst_done and
   // lock_lost_pulse cannot glitch. The async reset forces the safe values
   // immediately. Because it never passes through RUN, it never registers as
   // a lock loss.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= WAIT_LOCK;
         cnt_q           <= '0;
         sys_rst         <= 1'b1;
         rst_done        <= 1'b0;
         lock_lost_pulse <= 1'b0;
         lock_loss_count <= 8'd0;
      end else begin
         lock_lost_pulse <= 1'b0;
         if (clear_count) begin
            lock_loss_count <= 8'd0;
         end

         case (state_q)
            WAIT_LOCK: begin
               cnt_q <= '0;
               if (locked_s) begin
                  state_q <= STABLE;
               end
            end

            STABLE: begin
               if (!locked_s) begin
                  state_q <= WAIT_LOCK;
                  cnt_q   <= '0;
               end else if (cnt_q == STABLE_LAST) begin
                  state_q <= HOLD;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            HOLD: begin
               if (!locked_s) begin
                  state_q <= WAIT_LOCK;
                  cnt_q   <= '0;
               end else if (cnt_q == HOLD_LAST) begin
                  state_q  <= RUN;
                  cnt_q    <= '0;
                  sys_rst  <= 1'b0;
                  rst_done <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            RUN: begin
               if (!locked_s) begin
                  state_q         <= WAIT_LOCK;
                  sys_rst         <= 1'b1;
                  rst_done        <= 1'b0;
                  lock_lost_pulse <= 1'b1;
                  // A clear in the same cycle wins first, then this loss is
                  // counted on top of it.
                  if (clear_count) begin
                     lock_loss_count <= 8'd1;
                  end else if (lock_loss_count != 8'hFF) begin
                     lock_loss_count <= lock_loss_count + 8'd1;
                  end
               end
            end

            default: begin
               state_q <= WAIT_LOCK;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign state_o = state_q;

endmodule
